// File: rtl/seq_mult32.sv
// Sequential 32x32 unsigned shift-add multiplier: one add/shift step per clock,
// 32 steps per product, start/done handshake around a three-state FSM.
module seq_mult32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [31:0] product_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] sum;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  // The adder is 33 bits wide so its carry lands in hi[31] after the shift.
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);

  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && start) begin
      mcand_d = a;
      hi_d    = 32'd0;
      lo_d    = b;
      cnt_d   = 5'd0;
    end else if (state_q == CALC) begin
      hi_d  = sum[32:1];
      lo_d  = {sum[0], lo_q[31:1]};
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= 5'd0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product    = {hi_q, lo_q};
  assign product_lo = lo_q;

endmodule

// File: tb/tb_seq_mult32.sv
// Self-checking bench for seq_mult32: expected products are queued at start and
// compared by a monitor whenever the DUT pulses done.
module tb_seq_mult32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] product_lo;

  seq_mult32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .product_lo (product_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          last_done_cyc = 0;
  logic        done_prev = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("product", product, e);
        check("product_lo", {32'd0, product_lo}, {32'd0, e[31:0]});
      end
      check("busy_with_done", {63'd0, busy}, 64'd0);
      check("done_twice", {63'd0, done_prev}, 64'd0);
    end
    done_prev = rst_n && done;
  end

  // Issues one multiply and waits (bounded) for its done pulse. With hold_start
  // set, start stays high during CALC with scrambled operands.
  task automatic do_mult(input logic [31:0] av, input logic [31:0] bv, input bit hold_start);
    int  busy_cnt;
    bit  seen;
    busy_cnt = 0;
    seen     = 1'b0;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back({32'd0, av} * {32'd0, bv});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hold_start) begin
        a = ~av;
        b = bv + 32'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        last_done_cyc = cyc;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check("done_seen", {63'd0, seen}, 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'd32);
  endtask

  initial begin
    int d1;
    int extra;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    #1;
    check("rst_product", product, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_mult(32'd7, 32'd6, 1'b0);
    check("lit_7x6", product, 64'h0000_0000_0000_002A);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("lit_max", product, 64'hFFFF_FFFE_0000_0001);
    do_mult(32'd0, 32'h1234_5678, 1'b0);
    do_mult(32'h8000_0000, 32'd2, 1'b0);
    check("lit_msb", product, 64'h0000_0001_0000_0000);

    // start held through CALC: exactly one result, from the sampled operands.
    do_mult(32'h0001_2345, 32'h0000_0ABC, 1'b1);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("extra_done", 64'(extra), 64'd0);

    // Reset during CALC cycle 10 aborts without a done pulse.
    @(negedge clk);
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_product", product, 64'd0);
    check("abort_lo", {32'd0, product_lo}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort_no_done", 64'(extra), 64'd0);
    do_mult(32'd3, 32'd5, 1'b0);
    check("lit_3x5", product, 64'd15);

    // Back-to-back: start in the IDLE cycle after done. Start is only sampled
    // in IDLE, so the done-to-done spacing is 34 cycles.
    d1 = last_done_cyc;
    do_mult(32'h0001_0000, 32'h0001_0000, 1'b0);
    check("b2b_gap", 64'(last_done_cyc - d1), 64'd34);

    for (int i = 0; i < 4; i++) begin
      do_mult($urandom, $urandom, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
